// File: rtl/cajero_param.sv
// Parametrised ATM transaction controller: card intake, positional PIN check with lockout,
// and withdrawal/deposit session against a registered balance. Optional macro: CAJERO_LIMITE_EN.
module cajero_param #(
   parameter int PIN_DIGITS    = 4,
   parameter int MONTO_W       = 16,
   parameter int BAL_W         = 64,
   parameter int MAX_INTENTOS  = 3,
   parameter int COMISION_VAL  = 1,
   parameter int BAL_INIT      = 15,
   parameter int LIMITE_RETIRO = 1000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    TARJETA_RECIBIDA,
   input  logic                    TIPO_DE_TARJETA,
   input  logic [4*PIN_DIGITS-1:0] PIN,
   input  logic [3:0]              DIGITO,
   input  logic                    DIGITO_STB,
   input  logic                    TIPO_TRANS,
   input  logic [MONTO_W-1:0]      MONTO,
   input  logic                    MONTO_STB,
   output logic                    PIN_INCORRECTO,
   output logic                    ADVERTENCIA,
   output logic                    BLOQUEO,
   output logic                    ENTREGAR_DINERO,
   output logic                    BALANCE_ACTUALIZADO,
   output logic                    FONDOS_INSUFICIENTES,
   output logic                    COMISION,
   output logic                    LIMITE_EXCEDIDO,
   output logic [BAL_W-1:0]        BALANCE
);
   localparam int CNT_W  = $clog2(PIN_DIGITS + 1);
   localparam int FAIL_W = $clog2(MAX_INTENTOS + 1);
   localparam logic [BAL_W-1:0]  BAL_RST    = BAL_W'(BAL_INIT);
   localparam logic [BAL_W-1:0]  FEE        = BAL_W'(COMISION_VAL);
   localparam logic [FAIL_W-1:0] FAIL_AVISO = FAIL_W'(MAX_INTENTOS - 1);
   localparam logic [FAIL_W-1:0] FAIL_MAX   = FAIL_W'(MAX_INTENTOS);
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PIN_DIGITS - 1);

   typedef enum logic [2:0] {
      ESPERA      = 3'd0,
      INGRESO_PIN = 3'd1,
      VERIFICA    = 3'd2,
      SESION      = 3'd3,
      BLOQUEADO   = 3'd4
   } estado_t;

   estado_t             state_r, state_s;
   logic [CNT_W-1:0]    dig_cnt_r, dig_cnt_s;
   logic                mism_r, mism_s;
   logic [FAIL_W-1:0]   fails_r, fails_s;
   logic                com_r, com_s;
   logic [BAL_W-1:0]    bal_r, bal_s;
   logic                pi_r, pi_s, ent_r, ent_s, act_r, act_s, fon_r, fon_s, lim_r, lim_s;
   logic                adv_r, blq_r;
   logic [4*PIN_DIGITS-1:0] pin_sh_s;
   logic [3:0]          nib_s;
   logic [BAL_W-1:0]    cost_s;
   logic [BAL_W:0]      dep_s;
`ifdef CAJERO_LIMITE_EN
   logic [MONTO_W:0]    acum_r, acum_s;
   logic [MONTO_W+1:0]  lim_sum_s;
`endif

   // Expected nibble: first digit entered is the most significant nibble of PIN.
   always_comb begin
      pin_sh_s = PIN << {dig_cnt_r, 2'b00};
      nib_s    = pin_sh_s[4*PIN_DIGITS-1 -: 4];
      cost_s   = BAL_W'(MONTO) + (com_r ? FEE : {BAL_W{1'b0}});
      dep_s    = {1'b0, bal_r} + (BAL_W + 1)'(MONTO);
`ifdef CAJERO_LIMITE_EN
      lim_sum_s = (MONTO_W + 2)'(acum_r) + (MONTO_W + 2)'(MONTO);
`endif
   end

   // Next-state and response logic.
   always_comb begin
      state_s   = state_r;
      dig_cnt_s = dig_cnt_r;
      mism_s    = mism_r;
      fails_s   = fails_r;
      com_s     = com_r;
      bal_s     = bal_r;
      pi_s      = 1'b0;
      ent_s     = 1'b0;
      act_s     = 1'b0;
      fon_s     = 1'b0;
      lim_s     = 1'b0;
`ifdef CAJERO_LIMITE_EN
      acum_s    = acum_r;
`endif
      case (state_r)
         ESPERA: begin
            if (TARJETA_RECIBIDA) begin
               state_s   = INGRESO_PIN;
               com_s     = TIPO_DE_TARJETA;
               dig_cnt_s = {CNT_W{1'b0}};
               mism_s    = 1'b0;
            end else begin
               com_s = 1'b0;
            end
         end
         INGRESO_PIN, VERIFICA, SESION: begin
            if (!TARJETA_RECIBIDA) begin
               // Card pulled: abandon partial work, keep the fail count.
               state_s   = ESPERA;
               dig_cnt_s = {CNT_W{1'b0}};
               mism_s    = 1'b0;
               com_s     = 1'b0;
            end else if (state_r == INGRESO_PIN) begin
               if (DIGITO_STB) begin
                  mism_s    = mism_r | (DIGITO != nib_s);
                  dig_cnt_s = dig_cnt_r + CNT_W'(1);
                  state_s   = (dig_cnt_r == CNT_LAST) ? VERIFICA : INGRESO_PIN;
               end else begin
                  state_s = INGRESO_PIN;
               end
            end else if (state_r == VERIFICA) begin
               dig_cnt_s = {CNT_W{1'b0}};
               mism_s    = 1'b0;
               if (!mism_r) begin
                  fails_s = {FAIL_W{1'b0}};
                  state_s = SESION;
`ifdef CAJERO_LIMITE_EN
                  acum_s  = {(MONTO_W + 1){1'b0}};
`endif
               end else begin
                  pi_s    = 1'b1;
                  fails_s = fails_r + FAIL_W'(1);
                  state_s = (fails_r == FAIL_AVISO) ? BLOQUEADO : INGRESO_PIN;
               end
            end else if (MONTO_STB) begin
               if (TIPO_TRANS) begin
`ifdef CAJERO_LIMITE_EN
                  if (lim_sum_s > (MONTO_W + 2)'(LIMITE_RETIRO)) begin
                     lim_s = 1'b1;
                  end else if (cost_s <= bal_r) begin
                     bal_s  = bal_r - cost_s;
                     ent_s  = 1'b1;
                     act_s  = 1'b1;
                     acum_s = lim_sum_s[MONTO_W:0];
                  end else begin
                     fon_s = 1'b1;
                  end
`else
                  if (cost_s <= bal_r) begin
                     bal_s = bal_r - cost_s;
                     ent_s = 1'b1;
                     act_s = 1'b1;
                  end else begin
                     fon_s = 1'b1;
                  end
`endif
               end else begin
                  bal_s = dep_s[BAL_W] ? {BAL_W{1'b1}} : dep_s[BAL_W-1:0];
                  act_s = 1'b1;
               end
            end else begin
               state_s = SESION;
            end
         end
         BLOQUEADO: begin
            state_s = BLOQUEADO;
         end
         default: begin
            state_s = ESPERA;
         end
      endcase
   end

   // State, balance and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ESPERA;
         dig_cnt_r <= {CNT_W{1'b0}};
         mism_r    <= 1'b0;
         fails_r   <= {FAIL_W{1'b0}};
         com_r     <= 1'b0;
         bal_r     <= BAL_RST;
         pi_r      <= 1'b0;
         ent_r     <= 1'b0;
         act_r     <= 1'b0;
         fon_r     <= 1'b0;
         lim_r     <= 1'b0;
         adv_r     <= 1'b0;
         blq_r     <= 1'b0;
`ifdef CAJERO_LIMITE_EN
         acum_r    <= {(MONTO_W + 1){1'b0}};
`endif
      end else begin
         state_r   <= state_s;
         dig_cnt_r <= dig_cnt_s;
         mism_r    <= mism_s;
         fails_r   <= fails_s;
         com_r     <= com_s;
         bal_r     <= bal_s;
         pi_r      <= pi_s;
         ent_r     <= ent_s;
         act_r     <= act_s;
         fon_r     <= fon_s;
         lim_r     <= lim_s;
         adv_r     <= (fails_s == FAIL_AVISO) && (state_s != BLOQUEADO);
         blq_r     <= (state_s == BLOQUEADO);
`ifdef CAJERO_LIMITE_EN
         acum_r    <= acum_s;
`endif
      end
   end

   assign PIN_INCORRECTO       = pi_r;
   assign ADVERTENCIA          = adv_r;
   assign BLOQUEO              = blq_r;
   assign ENTREGAR_DINERO      = ent_r;
   assign BALANCE_ACTUALIZADO  = act_r;
   assign FONDOS_INSUFICIENTES = fon_r;
   assign COMISION             = com_r;
   assign LIMITE_EXCEDIDO      = lim_r;
   assign BALANCE              = bal_r;
endmodule

// File: tb/tb_cajero_param.sv
// Scoreboard bench for cajero_param: expected output vectors are queued as stimulus is
// driven and compared one cycle later at the falling edge.
module tb_cajero_param;
   logic        clk = 1'b0;
   logic        reset;
   logic        TARJETA_RECIBIDA, TIPO_DE_TARJETA;
   logic [15:0] PIN;
   logic [3:0]  DIGITO;
   logic        DIGITO_STB, TIPO_TRANS, MONTO_STB;
   logic [15:0] MONTO;
   logic        PIN_INCORRECTO, ADVERTENCIA, BLOQUEO, ENTREGAR_DINERO;
   logic        BALANCE_ACTUALIZADO, FONDOS_INSUFICIENTES, COMISION, LIMITE_EXCEDIDO;
   logic [63:0] BALANCE;

   typedef struct {
      string       tag;
      logic [71:0] v;
   } exp_t;

   exp_t        sb[$];
   int          n_vec  = 0;
   int          n_miss = 0;
   logic [63:0] m_bal;
   int          m_fails;
   logic        m_com, m_ses, m_blq, m_adv;
   int          m_acum;

   cajero_param dut (
      .clk(clk), .reset(reset),
      .TARJETA_RECIBIDA(TARJETA_RECIBIDA), .TIPO_DE_TARJETA(TIPO_DE_TARJETA),
      .PIN(PIN), .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB),
      .TIPO_TRANS(TIPO_TRANS), .MONTO(MONTO), .MONTO_STB(MONTO_STB),
      .PIN_INCORRECTO(PIN_INCORRECTO), .ADVERTENCIA(ADVERTENCIA), .BLOQUEO(BLOQUEO),
      .ENTREGAR_DINERO(ENTREGAR_DINERO), .BALANCE_ACTUALIZADO(BALANCE_ACTUALIZADO),
      .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES), .COMISION(COMISION),
      .LIMITE_EXCEDIDO(LIMITE_EXCEDIDO), .BALANCE(BALANCE)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h (pi adv blq ent act fon com lim | balance)",
                  tag, obs, exp);
      end
   endtask

   // Push an expectation built from the model's levels plus the given pulses.
   task automatic expect_out(input string tag, input logic pi, input logic ent,
                             input logic act, input logic fon, input logic lim);
      exp_t e;
      e.tag = tag;
      e.v   = {pi, m_adv, m_blq, ent, act, fon, m_com, lim, m_bal};
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk_eq(e.tag, {PIN_INCORRECTO, ADVERTENCIA, BLOQUEO, ENTREGAR_DINERO,
                        BALANCE_ACTUALIZADO, FONDOS_INSUFICIENTES, COMISION,
                        LIMITE_EXCEDIDO, BALANCE}, e.v);
      end
      DIGITO_STB = 1'b0;
      MONTO_STB  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      TARJETA_RECIBIDA = 1'b0; TIPO_DE_TARJETA = 1'b0; DIGITO = 4'd0;
      DIGITO_STB = 1'b0; TIPO_TRANS = 1'b0; MONTO = 16'd0; MONTO_STB = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_bal = 64'd15; m_fails = 0; m_com = 1'b0; m_ses = 1'b0;
      m_blq = 1'b0; m_adv = 1'b0; m_acum = 0;
      expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic insert_card(input logic foreign);
      TARJETA_RECIBIDA = 1'b1;
      TIPO_DE_TARJETA  = foreign;
      m_com = foreign;
      expect_out("card_in", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic enter_pin(input logic [15:0] d);
      logic ok;
      for (int i = 0; i < 4; i++) begin
         DIGITO     = d[15 - 4*i -: 4];
         DIGITO_STB = 1'b1;
         expect_out("digit", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      ok = (d == PIN);
      if (m_blq) begin
         expect_out("locked_verify", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (ok) begin
         m_fails = 0; m_adv = 1'b0; m_ses = 1'b1; m_acum = 0;
         expect_out("pin_ok", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
         m_fails++;
         m_blq = (m_fails == 3);
         m_adv = (m_fails == 2);
         expect_out("pin_bad", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      tick();
   endtask

   task automatic monto_op(input string tag, input logic wd, input logic [15:0] amt);
      logic [63:0] cost;
      TIPO_TRANS = wd;
      MONTO      = amt;
      MONTO_STB  = 1'b1;
      if (!m_ses) begin
         expect_out({tag, "_ignored"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (!wd) begin
         m_bal = m_bal + 64'(amt);
         expect_out(tag, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end else begin
         cost = 64'(amt) + (m_com ? 64'd1 : 64'd0);
`ifdef CAJERO_LIMITE_EN
         if (m_acum + int'(amt) > 1000) begin
            expect_out(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         end else
`endif
         if (cost <= m_bal) begin
            m_bal  = m_bal - cost;
            m_acum = m_acum + int'(amt);
            expect_out(tag, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
         end else begin
            expect_out(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         end
      end
      tick();
   endtask

   task automatic remove_card(input logic with_strobe);
      TARJETA_RECIBIDA = 1'b0;
      MONTO_STB  = with_strobe;
      TIPO_TRANS = 1'b0;
      MONTO      = 16'd7;
      m_ses = 1'b0;
      if (!m_blq) m_com = 1'b0;
      expect_out("card_out", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      PIN = 16'h1234;
      // Own card, correct PIN, deposit, card removal.
      do_reset();
      insert_card(1'b0);
      monto_op("dep_in_pin_entry", 1'b0, 16'd50);
      enter_pin(16'h1234);
      monto_op("dep100", 1'b0, 16'd100);
      remove_card(1'b0);
      monto_op("dep_in_idle", 1'b0, 16'd9);

      // Wrong order, then lockout; correct PIN afterwards has no effect.
      do_reset();
      insert_card(1'b0);
      enter_pin(16'h4321);
      enter_pin(16'h1235);
      enter_pin(16'h0000);
      enter_pin(16'h1234);
      monto_op("wd_locked", 1'b1, 16'd1);
      remove_card(1'b0);
      insert_card(1'b0);
      expect_out("still_locked", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();

      // Foreign card: fee, exact-balance withdrawal, back-to-back rejection.
      do_reset();
      insert_card(1'b1);
      enter_pin(16'h4321);
      enter_pin(16'h1234);
      monto_op("wd14_fee", 1'b1, 16'd14);
      monto_op("wd1_nofunds", 1'b1, 16'd1);
      monto_op("dep3", 1'b0, 16'd3);
      monto_op("wd2_exact", 1'b1, 16'd2);
      remove_card(1'b1);

      // Withdrawal ceiling (reduces to plain funds check without the limit macro).
      do_reset();
      insert_card(1'b0);
      enter_pin(16'h1234);
      monto_op("dep4985", 1'b0, 16'd4985);
      monto_op("wd600", 1'b1, 16'd600);
      monto_op("wd500", 1'b1, 16'd500);
      monto_op("wd400", 1'b1, 16'd400);
      remove_card(1'b0);

      while (sb.size() > 0) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
